// File: rtl/game_flow_manager.sv
// Game flow sequencer: menu, play, died/win/game-over screens, level and lives
// bookkeeping, and a shared seconds timer for the timed screens.
module game_flow_manager #(
    parameter int unsigned NUM_LEVELS   = 4,
    parameter int unsigned LVL_W        = 2,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned DIED_SEC     = 3,
    parameter int unsigned WIN_SEC      = 3,
    parameter int unsigned OVER_SEC     = 5,
    parameter int unsigned AUTO_ADVANCE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_sec,
    input  logic             bumpy_died,
    input  logic             level_comp,
    input  logic             menu_comp,
    input  logic [LVL_W-1:0] lvl_selected,
    output logic             menu_screen,
    output logic             died_screen,
    output logic             win_screen,
    output logic             over_screen,
    output logic             reset_lvl_N,
    output logic [LVL_W-1:0] lvl,
    output logic [3:0]       lives_left,
    output logic             game_won
);

    localparam logic [LVL_W-1:0] LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
    localparam logic [3:0]       DIED_T     = 4'(DIED_SEC);
    localparam logic [3:0]       WIN_T      = 4'(WIN_SEC);
    localparam logic [3:0]       OVER_T     = 4'(OVER_SEC);
    localparam logic [3:0]       TIMER_MAX  = 4'hF;

    // One-hot encoding so every screen select is a bare state flop.
    typedef enum logic [4:0] {
        MENU = 5'b00001,
        DIED = 5'b00010,
        WIN  = 5'b00100,
        OVER = 5'b01000,
        PLAY = 5'b10000
    } state_t;

    state_t     state;
    logic [3:0] timer;
    logic       entry;

    assign menu_screen = state[0];
    assign died_screen = state[1];
    assign win_screen  = state[2];
    assign over_screen = state[3];
    // Gated by reset so the play field is held in reset during the reset cycle itself.
    assign reset_lvl_N = state[4] & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MENU;
            timer      <= 4'd0;
            entry      <= 1'b1;
            lvl        <= '0;
            lives_left <= LIVES_INIT;
            game_won   <= 1'b0;
        end else begin
            game_won <= 1'b0;
            entry    <= 1'b0;

            // Strobes in the first cycle of a state are not counted; the timer saturates.
            if (one_sec && !entry && timer != TIMER_MAX &&
                (state == DIED || state == WIN || state == OVER)) begin
                timer <= timer + 4'd1;
            end

            // Every transition below restarts the timer and marks the entry cycle.
            unique case (state)
                MENU: begin
                    if (menu_comp) begin
                        lvl        <= (lvl_selected > LAST_LVL) ? LAST_LVL : lvl_selected;
                        lives_left <= LIVES_INIT;
                        state      <= PLAY;
                        timer      <= 4'd0;
                        entry      <= 1'b1;
                    end
                end
                PLAY: begin
                    if (level_comp) begin
                        state <= WIN;
                        timer <= 4'd0;
                        entry <= 1'b1;
                    end else if (bumpy_died) begin
                        timer <= 4'd0;
                        entry <= 1'b1;
                        if (lives_left > 4'd1) begin
                            lives_left <= lives_left - 4'd1;
                            state      <= DIED;
                        end else begin
                            lives_left <= 4'd0;
                            state      <= OVER;
                        end
                    end
                end
                DIED: begin
                    if (timer >= DIED_T) begin
                        state <= PLAY;
                        timer <= 4'd0;
                        entry <= 1'b1;
                    end
                end
                WIN: begin
                    if (timer >= WIN_T) begin
                        timer <= 4'd0;
                        entry <= 1'b1;
                        if (AUTO_ADVANCE != 0 && lvl < LAST_LVL) begin
                            lvl   <= lvl + LVL_W'(1);
                            state <= PLAY;
                        end else begin
                            state    <= MENU;
                            game_won <= (lvl == LAST_LVL);
                        end
                    end
                end
                OVER: begin
                    if (timer >= OVER_T) begin
                        state <= MENU;
                        timer <= 4'd0;
                        entry <= 1'b1;
                    end
                end
                default: begin
                    state <= MENU;
                    timer <= 4'd0;
                    entry <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_manager.sv
// Testbench for game_flow_manager: per-cycle vector table through a scoreboard
// queue, plus a hand-written sequence for the AUTO_ADVANCE = 0 variant.
module tb_game_flow_manager;

    logic       clk = 1'b0;
    logic       reset, one_sec, bumpy_died, level_comp, menu_comp;
    logic [2:0] sel;

    logic       m0, d0, w0, o0, rln0, won0;
    logic [2:0] lvl0;
    logic [3:0] lives0;
    logic       m1, d1, w1, o1, rln1, won1;
    logic [1:0] lvl1;
    logic [3:0] lives1;

    always #5 clk = ~clk;

    game_flow_manager #(
        .NUM_LEVELS(4), .LVL_W(3), .LIVES(3), .DIED_SEC(3), .WIN_SEC(3),
        .OVER_SEC(5), .AUTO_ADVANCE(1)
    ) dut0 (
        .clk(clk), .reset(reset), .one_sec(one_sec), .bumpy_died(bumpy_died),
        .level_comp(level_comp), .menu_comp(menu_comp), .lvl_selected(sel),
        .menu_screen(m0), .died_screen(d0), .win_screen(w0), .over_screen(o0),
        .reset_lvl_N(rln0), .lvl(lvl0), .lives_left(lives0), .game_won(won0)
    );

    game_flow_manager #(
        .NUM_LEVELS(4), .LVL_W(2), .LIVES(3), .DIED_SEC(3), .WIN_SEC(3),
        .OVER_SEC(5), .AUTO_ADVANCE(0)
    ) dut1 (
        .clk(clk), .reset(reset), .one_sec(one_sec), .bumpy_died(bumpy_died),
        .level_comp(level_comp), .menu_comp(menu_comp), .lvl_selected(sel[1:0]),
        .menu_screen(m1), .died_screen(d1), .win_screen(w1), .over_screen(o1),
        .reset_lvl_N(rln1), .lvl(lvl1), .lives_left(lives1), .game_won(won1)
    );

    typedef struct packed {
        logic [3:0] scr;   // {menu, died, win, over}
        logic       rln;
        logic [2:0] lvl;
        logic [3:0] lives;
        logic       won;
        logic [3:0] tmr;
    } obs_t;

    typedef struct packed {
        logic       rst, os, bd, lc, mc;
        logic [2:0] sel;
        obs_t       exp;
    } vec_t;

    localparam int M = 8, D = 4, W = 2, O = 1, P = 0;

    vec_t vecs[$];
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(input int r, input int os, input int bd, input int lc,
                               input int mc, input int s, input int scr, input int rl,
                               input int lv, input int li, input int wn, input int t);
        vec_t x;
        x.rst       = 1'(r);
        x.os        = 1'(os);
        x.bd        = 1'(bd);
        x.lc        = 1'(lc);
        x.mc        = 1'(mc);
        x.sel       = 3'(s);
        x.exp.scr   = 4'(scr);
        x.exp.rln   = 1'(rl);
        x.exp.lvl   = 3'(lv);
        x.exp.lives = 4'(li);
        x.exp.won   = 1'(wn);
        x.exp.tmr   = 4'(t);
        return x;
    endfunction

    task automatic drive(input logic r, input logic os, input logic bd, input logic lc,
                         input logic mc, input logic [2:0] s);
        reset      = r;
        one_sec    = os;
        bumpy_died = bd;
        level_comp = lc;
        menu_comp  = mc;
        sel        = s;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic obs_t sample0();
        obs_t s;
        s.scr   = {m0, d0, w0, o0};
        s.rln   = rln0;
        s.lvl   = lvl0;
        s.lives = lives0;
        s.won   = won0;
        s.tmr   = dut0.timer;
        return s;
    endfunction

    initial begin
        obs_t got, want;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        //       rst os bd lc mc sel   scr rln lvl lives won tmr
        vecs.push_back(v(1, 0, 0, 0, 0, 0,  M, 0, 0, 3, 0, 0));  // reset
        vecs.push_back(v(0, 0, 0, 0, 1, 2,  P, 1, 2, 3, 0, 0));  // start on level 2
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  P, 1, 2, 3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 2, 2, 0, 0));  // death
        vecs.push_back(v(0, 1, 1, 0, 0, 0,  D, 0, 2, 2, 0, 0));  // entry strobe ignored
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 2, 2, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 2, 2, 0, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 2, 2, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  P, 1, 2, 2, 0, 0));  // back to play
        vecs.push_back(v(0, 0, 1, 1, 0, 0,  W, 0, 2, 2, 0, 0));  // win beats death
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 2, 2, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 2, 2, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  W, 0, 2, 2, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 2, 2, 0, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 2, 2, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  P, 1, 3, 2, 0, 0));  // advance to level 3
        vecs.push_back(v(0, 0, 0, 1, 0, 0,  W, 0, 3, 2, 0, 0));  // win last level
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 3, 2, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 3, 2, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 3, 2, 0, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 3, 2, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  M, 0, 3, 2, 1, 0));  // game_won pulse
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  M, 0, 3, 2, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 7,  P, 1, 3, 3, 0, 0));  // level clamp
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0,  M, 0, 0, 3, 0, 0));  // reset from DIED
        vecs.push_back(v(0, 0, 0, 0, 1, 1,  P, 1, 1, 3, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0,  W, 0, 1, 3, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 1, 3, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 1, 3, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  W, 0, 1, 3, 0, 2));
        vecs.push_back(v(1, 1, 0, 1, 0, 0,  M, 0, 0, 3, 0, 0));  // reset mid-WIN
        vecs.push_back(v(0, 0, 1, 1, 0, 0,  M, 0, 0, 3, 0, 0));  // events ignored in MENU
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  P, 1, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 0, 2, 0, 0));  // first of three deaths
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 2, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 2, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 2, 0, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 2, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  P, 1, 0, 2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 0, 1, 0, 0));  // second death
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 1, 0, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 0, 1, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  P, 1, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  O, 0, 0, 0, 0, 0));  // last life -> OVER
        vecs.push_back(v(0, 1, 1, 0, 0, 0,  O, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  O, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  O, 0, 0, 0, 0, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  O, 0, 0, 0, 0, 3));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  O, 0, 0, 0, 0, 4));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  O, 0, 0, 0, 0, 5));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  M, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 3,  P, 1, 3, 3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 0));  // bumpy_died held 10 cycles
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0,  D, 0, 3, 2, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 1));
        vecs.push_back(v(0, 1, 1, 0, 0, 0,  D, 0, 3, 2, 0, 2));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 2));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 2));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 2));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  D, 0, 3, 2, 0, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  D, 0, 3, 2, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  P, 1, 3, 2, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].os, vecs[i].bd, vecs[i].lc, vecs[i].mc, vecs[i].sel);
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            got  = sample0();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL vec%0d: got scr=%b rln=%b lvl=%0d lives=%0d won=%b tmr=%0d, expected scr=%b rln=%b lvl=%0d lives=%0d won=%b tmr=%0d",
                         i, got.scr, got.rln, got.lvl, got.lives, got.won, got.tmr,
                         want.scr, want.rln, want.lvl, want.lives, want.won, want.tmr);
            end
        end

        // AUTO_ADVANCE = 0 instance: a win on level 1 returns to MENU without a pulse.
        for (int c = 0; c < 9; c++) begin
            case (c)
                0:       drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
                1:       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
                2:       drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
                3, 4, 5, 6: drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            endcase
            @(posedge clk);
            #1;
            chk($sformatf("aa0_won_c%0d", c), 32'(won1), 32'd0);
            if (c == 0) chk("aa0_reset_menu", 32'(m1), 32'd1);
            if (c == 1) chk("aa0_play_rln", 32'(rln1), 32'd1);
            if (c == 2) chk("aa0_win_screen", 32'(w1), 32'd1);
            if (c == 7) begin
                chk("aa0_menu_after_win", 32'(m1), 32'd1);
                chk("aa0_lvl_kept", 32'(lvl1), 32'd1);
                chk("aa1_advance_lvl", 32'(lvl0), 32'd2);
                chk("aa1_advance_play", 32'(rln0), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_manager.md
GAME_FLOW_MANAGER -- requirements
Module: game_flow_manager

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 4, meaning the number of playable levels (2..16).
REQ-002 SHALL have parameter LVL_W, default 2, meaning the level index width; LVL_W SHALL be at least clog2(NUM_LEVELS).
REQ-003 SHALL have parameter LIVES, default 3, meaning the lives loaded at game start (1..15).
REQ-004 SHALL have parameters DIED_SEC / WIN_SEC / OVER_SEC, defaults 3 / 3 / 5, meaning screen durations in one_sec strobes (each 1..15).
REQ-005 SHALL have parameter AUTO_ADVANCE, default 1, where 1 means the next level starts after the win screen and 0 means a return to the menu.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port one_sec, input, 1 bit: single-cycle strobe once per second, sampled as a clk enable and never used as a clock.
REQ-009 SHALL have ports bumpy_died, level_comp and menu_comp, each input, 1 bit: event pulses.
REQ-010 SHALL have port lvl_selected, input, LVL_W bits: level chosen in the menu.
REQ-011 SHALL have ports menu_screen, died_screen, win_screen and over_screen, each output, 1 bit: screen selects.
REQ-012 SHALL have port reset_lvl_N, output, 1 bit: active-low level reset to the play-field blocks.
REQ-013 SHALL have port lvl, output, LVL_W bits: current level index.
REQ-014 SHALL have port lives_left, output, 4 bits: remaining lives.
REQ-015 SHALL have port game_won, output, 1 bit: one-cycle pulse when the last level's win screen ends.

Function
REQ-016 SHALL implement a registered FSM with states MENU, PLAY, DIED, WIN and OVER.
REQ-017 SHALL decode the screen outputs from the state register, with at most one high and none high in PLAY.
REQ-018 SHALL drive reset_lvl_N = 1 only in PLAY and never while reset is high.
REQ-019 In MENU, menu_comp SHALL load lvl = min(lvl_selected, NUM_LEVELS-1) and lives_left = LIVES, then go to PLAY on the next cycle.
REQ-020 In PLAY, level_comp SHALL go to WIN; level_comp SHALL take priority when it coincides with bumpy_died, and no life is lost in that case.
REQ-021 In PLAY, bumpy_died with lives_left > 1 SHALL decrement lives_left and go to DIED.
REQ-022 In PLAY, bumpy_died with lives_left == 1 SHALL set lives_left = 0 and go to OVER.
REQ-023 A single 4-bit timer SHALL clear on every state entry and increment on each one_sec strobe in DIED, WIN and OVER.
REQ-024 A one_sec strobe in the entry cycle of a state SHALL NOT be counted.
REQ-025 DIED SHALL return to PLAY in the cycle after the DIED_SEC-th counted strobe, with lvl unchanged.
REQ-026 WIN, after WIN_SEC strobes with AUTO_ADVANCE = 1 and lvl < NUM_LEVELS-1, SHALL increment lvl and go to PLAY.
REQ-027 WIN, after WIN_SEC strobes in any other case, SHALL go to MENU; game_won SHALL pulse for one cycle if lvl == NUM_LEVELS-1.
REQ-028 OVER SHALL go to MENU after OVER_SEC strobes.
REQ-029 Event inputs SHALL be ignored outside the state that consumes them; a repeated or held bumpy_died in DIED SHALL cost no extra life.
REQ-030 A held-high event input SHALL act once per state entry only.
REQ-031 lvl SHALL never exceed NUM_LEVELS-1 and lives_left SHALL never underflow below 0.
REQ-032 The timer SHALL saturate and never wrap.
REQ-033 If one_sec is held high, it SHALL count once per clk cycle.

Reset
REQ-034 While reset = 1 at a clk edge, the block SHALL be in state MENU with menu_screen = 1, other screens 0, reset_lvl_N = 0, lvl = 0, lives_left = LIVES, timer = 0, game_won = 0.
REQ-035 Reset SHALL take priority over every event in the same cycle and SHALL abort any state or timer mid-count.
REQ-036 The block SHALL have no asynchronous paths.

Verification
REQ-037 Bench SHALL cover: reset, then menu_comp with lvl_selected = 2 -> PLAY next cycle, lvl = 2, lives_left = 3, reset_lvl_N = 1.
REQ-038 Bench SHALL cover: three bumpy_died pulses, each separated by the full DIED screen -> lives 2 then 1, then OVER with lives_left = 0; MENU after 5 strobes.
REQ-039 Bench SHALL cover: bumpy_died held 10 cycles in PLAY -> one life lost; died_screen high exactly until the cycle after the 3rd counted strobe.
REQ-040 Bench SHALL cover: level_comp and bumpy_died in the same cycle -> WIN, lives unchanged; after 3 strobes lvl increments and the block enters PLAY.
REQ-041 Bench SHALL cover: win on lvl = 3 with NUM_LEVELS = 4 -> game_won pulses one cycle, then MENU; with AUTO_ADVANCE = 0 a win on lvl = 1 returns to MENU with no pulse.
REQ-042 Bench SHALL cover: reset asserted mid-WIN with timer = 2 -> next cycle MENU, timer = 0, lvl = 0; lvl_selected = 7 with NUM_LEVELS = 4, LVL_W = 3 -> lvl = 3.
